// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline slice.
// Contents:
//   REG_W        - register index width (x0..x31)
//   F3_*         - load funct3 encodings (size and sign of the access)
//   wb_state_t   - occupancy states of the single-entry MEM/WB register
package riscv_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction for the writeback stage (purely combinational).
// Ports:
//   rdata      in  width : raw aligned memory word
//   off        in  2     : byte offset of the load address
//   funct3     in  3     : load size/sign
//   extracted  out width : selected byte/half/word, sign- or zero-extended
//   misaligned out 1     : access does not fit its natural alignment
// Unknown funct3 encodings behave as LW.
module load_align
  import riscv_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0] rdata,
  input  logic [1:0]       off,
  input  logic [2:0]       funct3,
  output logic [width-1:0] extracted,
  output logic             misaligned
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Split the low word into its four byte lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[off];
  assign sel_half = off[1] ? {byte_lane[3], byte_lane[2]}
                           : {byte_lane[1], byte_lane[0]};

  always_comb begin
    extracted  = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        extracted = {{(width-8){sel_byte[7]}}, sel_byte};
      end
      F3_LBU: begin
        extracted = {{(width-8){1'b0}}, sel_byte};
      end
      F3_LH: begin
        extracted  = {{(width-16){sel_half[15]}}, sel_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        extracted  = {{(width-16){1'b0}}, sel_half};
        misaligned = off[0];
      end
      default: begin
        // LW and any unknown encoding: whole word, must be word aligned.
        extracted  = rdata;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage of the five-stage RISC-V pipeline.
// Holds one instruction from the memory stage in a MEM/WB entry register,
// selects the ALU or the extracted load result and drives the register file
// write port in decode. Also provides a forwarding tap and a retire counter.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid / in_ready          : handshake from the memory stage
//   in_regWrite, in_memtoReg,
//   in_funct3, in_writeReg,
//   in_alu, in_rdata             : instruction fields to latch
//   flush                        : discard the held entry
//   wb_stall                     : register file port busy, hold the entry
//   wb_regWrite, wb_reg, wb_data : register file write port
//   fwd_valid, fwd_reg, fwd_data : forwarding tap (held entry)
//   misalign                     : pulse when a misaligned load retires
//   instret                      : retired-instruction count
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int width = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regWrite,
  input  logic             in_memtoReg,
  input  logic [2:0]       in_funct3,
  input  logic [REG_W-1:0] in_writeReg,
  input  logic [width-1:0] in_alu,
  input  logic [width-1:0] in_rdata,
  input  logic             flush,
  input  logic             wb_stall,
  output logic             wb_regWrite,
  output logic [REG_W-1:0] wb_reg,
  output logic [width-1:0] wb_data,
  output logic             fwd_valid,
  output logic [REG_W-1:0] fwd_reg,
  output logic [width-1:0] fwd_data,
  output logic             misalign,
  output logic [CNT_W-1:0] instret
);

  wb_state_t        state_reg;
  logic             regwrite_reg;
  logic             memtoreg_reg;
  logic [2:0]       funct3_reg;
  logic [REG_W-1:0] rd_reg;
  logic [width-1:0] alu_reg;
  logic [width-1:0] rdata_reg;
  logic [CNT_W-1:0] instret_reg;

  logic             full;
  logic             retire;
  logic             retire_go;
  logic             accept;
  logic [width-1:0] extracted;
  logic             misaligned;
  logic             load_misaligned;
  logic             writes_rd;
  logic [width-1:0] result;

  load_align #(
    .width(width)
  ) u_load_align (
    .rdata     (rdata_reg),
    .off       (alu_reg[1:0]),
    .funct3    (funct3_reg),
    .extracted (extracted),
    .misaligned(misaligned)
  );

  // Handshake: the entry frees up in the same cycle it retires, which
  // allows one instruction per cycle. A flush blocks acceptance while full.
  assign full      = (state_reg == FULL);
  assign retire    = full & ~flush;
  assign retire_go = retire & ~wb_stall;
  assign in_ready  = ~full | retire_go;
  assign accept    = in_valid & in_ready;

  // Alignment only matters for loads; ALU results may have any low bits.
  assign load_misaligned = memtoreg_reg & misaligned;
  assign writes_rd       = full & regwrite_reg & (rd_reg != '0) & ~load_misaligned;
  assign result          = memtoreg_reg ? extracted : alu_reg;

  // A reset cycle never writes: the held entry is being dropped.
  assign wb_regWrite = writes_rd & ~flush & ~wb_stall & ~rst;
  assign wb_reg      = rd_reg;
  assign wb_data     = result;

  // Forwarding ignores the stall so a held value stays visible to decode.
  assign fwd_valid = writes_rd;
  assign fwd_reg   = rd_reg;
  assign fwd_data  = result;

  assign misalign = retire_go & load_misaligned & ~rst;
  assign instret  = instret_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      funct3_reg   <= '0;
      rd_reg       <= '0;
      alu_reg      <= '0;
      rdata_reg    <= '0;
      instret_reg  <= '0;
    end else begin
      if (retire_go) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end

      if (accept) begin
        regwrite_reg <= in_regWrite;
        memtoreg_reg <= in_memtoReg;
        funct3_reg   <= in_funct3;
        rd_reg       <= in_writeReg;
        alu_reg      <= in_alu;
        rdata_reg    <= in_rdata;
      end

      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg <= FULL;
          end
        end
        FULL: begin
          // Stay FULL on accept (with retire) or on stall; otherwise the
          // entry either retired or was flushed.
          if (!accept && (flush || !wb_stall)) begin
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [2:0]  in_funct3;
  logic [4:0]  in_writereg;
  logic [31:0] in_alu;
  logic [31:0] in_rdata;
  logic        flush;
  logic        wb_stall;
  logic        wb_regwrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        misalign;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret;

  writeback_stage #(
    .width(32),
    .CNT_W(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_regWrite(in_regwrite),
    .in_memtoReg(in_memtoreg),
    .in_funct3  (in_funct3),
    .in_writeReg(in_writereg),
    .in_alu     (in_alu),
    .in_rdata   (in_rdata),
    .flush      (flush),
    .wb_stall   (wb_stall),
    .wb_regWrite(wb_regwrite),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .fwd_valid  (fwd_valid),
    .fwd_reg    (fwd_reg),
    .fwd_data   (fwd_data),
    .misalign   (misalign),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata);
    in_valid    = 1'b1;
    in_regwrite = rw;
    in_memtoreg = m2r;
    in_funct3   = f3;
    in_writereg = rd;
    in_alu      = alu;
    in_rdata    = rdata;
  endtask

  // Accept one instruction from an empty stage; returns at edge+2 with the
  // entry held and in_valid low.
  task automatic send(input logic rw, input logic m2r, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] rdata);
    drive(rw, m2r, f3, rd, alu, rdata);
    $display("txn rd=%0d alu=%h rdata=%h f3=%b memtoReg=%0d", rd, alu, rdata, f3, m2r);
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
    in_funct3 = 3'b0; in_writereg = 5'd0; in_alu = 32'd0; in_rdata = 32'd0;
    flush = 1'b0; wb_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    exp_instret = 64'd0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL reset_wb_regWrite got %b exp 0", wb_regwrite); end
    checks++; if (wb_reg !== 5'd0) begin errors++; $display("FAIL reset_wb_reg got %0d exp 0", wb_reg); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %b exp 0", fwd_valid); end
    checks++; if (fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got %h exp 0", fwd_data); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
  endtask

  task automatic test_alu();
    send(1'b1, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL alu_regWrite got %b exp 1", wb_regwrite); end
    checks++; if (wb_reg !== 5'd5) begin errors++; $display("FAIL alu_reg got %0d exp 5", wb_reg); end
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got %h exp 00001234", wb_data); end
    checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd5 || fwd_data !== 32'h1234) begin errors++; $display("FAIL alu_fwd got %b/%0d/%h exp 1/5/00001234", fwd_valid, fwd_reg, fwd_data); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL alu_instret_before got %0d exp 0", instret); end
    tick();
    exp_instret = 64'd1;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL alu_instret got %0d exp %0d", instret, exp_instret); end
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL alu_empty_regWrite got %b exp 0", wb_regwrite); end
  endtask

  task automatic test_loads();
    send(1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_1003, 32'h80FF_0000);
    checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", wb_data); end
    checks++; if (wb_regwrite !== 1'b1 || misalign !== 1'b0) begin errors++; $display("FAIL lb_write got %b/%b exp 1/0", wb_regwrite, misalign); end
    tick();
    send(1'b1, 1'b1, 3'b100, 5'd7, 32'h0000_1003, 32'h80FF_0000);
    checks++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", wb_data); end
    tick();
    send(1'b1, 1'b1, 3'b001, 5'd8, 32'h0000_1002, 32'h80FF_0000);
    checks++; if (wb_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data got %h exp ffff80ff", wb_data); end
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL lh_regWrite got %b exp 1", wb_regwrite); end
    tick();
    send(1'b1, 1'b1, 3'b101, 5'd8, 32'h0000_1000, 32'h1234_F00D);
    checks++; if (wb_data !== 32'h0000_F00D) begin errors++; $display("FAIL lhu_data got %h exp 0000f00d", wb_data); end
    tick();
    exp_instret = exp_instret + 64'd4;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL loads_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_misalign();
    send(1'b1, 1'b1, 3'b010, 5'd6, 32'h0000_1002, 32'hDEAD_BEEF);
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL mis_regWrite got %b exp 0", wb_regwrite); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL mis_fwd_valid got %b exp 0", fwd_valid); end
    tick();
    exp_instret = exp_instret + 64'd1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b exp 0", misalign); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL mis_instret got %0d exp %0d", instret, exp_instret); end
    // Misaligned halfword is dropped too
    send(1'b1, 1'b1, 3'b001, 5'd6, 32'h0000_1001, 32'hDEAD_BEEF);
    checks++; if (wb_regwrite !== 1'b0 || misalign !== 1'b1) begin errors++; $display("FAIL mis_lh got %b/%b exp 0/1", wb_regwrite, misalign); end
    tick();
    exp_instret = exp_instret + 64'd1;
  endtask

  task automatic test_rd0();
    send(1'b1, 1'b0, 3'b000, 5'd0, 32'h0000_ABCD, 32'h0);
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL rd0_regWrite got %b exp 0", wb_regwrite); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rd0_fwd_valid got %b exp 0", fwd_valid); end
    tick();
    exp_instret = exp_instret + 64'd1;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL rd0_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] base;
    base = exp_instret;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'b000, 5'(i + 1), 32'h100 + 32'(i), 32'h0);
      $display("txn rd=%0d alu=%h (stream)", i + 1, 32'h100 + 32'(i));
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b exp 1", i, in_ready); end
      if (i > 0) begin
        checks++; if (wb_regwrite !== 1'b1 || wb_reg !== 5'(i) || wb_data !== 32'h100 + 32'(i - 1)) begin errors++; $display("FAIL b2b_write_%0d got %b/%0d/%h exp 1/%0d/%h", i, wb_regwrite, wb_reg, wb_data, i, 32'h100 + 32'(i - 1)); end
      end
      tick();
    end
    // Entry now holds rd=4; stall with a fifth instruction waiting.
    drive(1'b1, 1'b0, 3'b000, 5'd5, 32'h104, 32'h0);
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d got %b exp 0", k, in_ready); end
      checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL stall_regWrite_%0d got %b exp 0", k, wb_regwrite); end
      checks++; if (wb_reg !== 5'd4 || wb_data !== 32'h103) begin errors++; $display("FAIL stall_hold_%0d got %0d/%h exp 4/00000103", k, wb_reg, wb_data); end
      checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd4) begin errors++; $display("FAIL stall_fwd_%0d got %b/%0d exp 1/4", k, fwd_valid, fwd_reg); end
      checks++; if (instret !== base + 64'd3) begin errors++; $display("FAIL stall_instret_%0d got %0d exp %0d", k, instret, base + 64'd3); end
      tick();
    end
    wb_stall = 1'b0;
    #1;
    checks++; if (wb_regwrite !== 1'b1 || wb_reg !== 5'd4 || in_ready !== 1'b1) begin errors++; $display("FAIL unstall_write got %b/%0d/%b exp 1/4/1", wb_regwrite, wb_reg, in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (wb_regwrite !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'h104) begin errors++; $display("FAIL last_write got %b/%0d/%h exp 1/5/00000104", wb_regwrite, wb_reg, wb_data); end
    checks++; if (instret !== base + 64'd4) begin errors++; $display("FAIL last_instret got %0d exp %0d", instret, base + 64'd4); end
    tick();
    exp_instret = base + 64'd5;
    checks++; if (instret !== exp_instret || wb_regwrite !== 1'b0) begin errors++; $display("FAIL b2b_done got %0d/%b exp %0d/0", instret, wb_regwrite, exp_instret); end
  endtask

  task automatic test_flush();
    send(1'b1, 1'b0, 3'b000, 5'd9, 32'h55, 32'h0);
    drive(1'b1, 1'b0, 3'b000, 5'd10, 32'h66, 32'h0);
    flush = 1'b1;
    #1;
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL flush_regWrite got %b exp 0", wb_regwrite); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (fwd_valid !== 1'b0 || wb_regwrite !== 1'b0) begin errors++; $display("FAIL flush_empty got %b/%b exp 0/0", fwd_valid, wb_regwrite); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b exp 1", in_ready); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL flush_instret got %0d exp %0d", instret, exp_instret); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b0, 3'b000, 5'd11, 32'h77, 32'h0);
    drive(1'b1, 1'b0, 3'b000, 5'd12, 32'h88, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (wb_regwrite !== 1'b0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL rstmid_port got %b/%0d/%h exp 0/0/0", wb_regwrite, wb_reg, wb_data); end
    checks++; if (fwd_valid !== 1'b0 || fwd_reg !== 5'd0 || fwd_data !== 32'd0) begin errors++; $display("FAIL rstmid_fwd got %b/%0d/%h exp 0/0/0", fwd_valid, fwd_reg, fwd_data); end
    checks++; if (instret !== 64'd0 || misalign !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_misc got %0d/%b/%b exp 0/0/1", instret, misalign, in_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_rd0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
